// File: rtl/fifo_skew_reader_pkg.sv
// Shared types and defaults for the skewed FIFO reader that feeds the systolic array's left edge.
package fifo_skew_reader_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam int unsigned DefaultRows  = 4;
  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultLen   = 4;

  // Step counter must hold T-1 = LEN+ROWS-2; never narrower than one bit.
  function automatic int unsigned step_cnt_width(int unsigned rows, int unsigned len);
    return (rows + len > 2) ? unsigned'($clog2(rows + len)) : 1;
  endfunction

endpackage

// File: rtl/fifo_skew_reader_if.sv
// Start/status, FIFO read side and array-facing row bus of the skewed reader.
interface fifo_skew_reader_if
  import fifo_skew_reader_pkg::*;
#(
  parameter int unsigned ROWS  = DefaultRows,
  parameter int unsigned WIDTH = DefaultWidth
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ROWS-1:0]       fifo_empty;
  logic [ROWS-1:0]       fifo_r_en;
  logic [ROWS*WIDTH-1:0] fifo_data;
  logic [ROWS*WIDTH-1:0] row_data;
  logic [ROWS-1:0]       row_valid;

  modport master (
    output start, fifo_empty, fifo_data,
    input  busy, done, fifo_r_en, row_data, row_valid
  );

  modport slave (
    input  start, fifo_empty, fifo_data,
    output busy, done, fifo_r_en, row_data, row_valid
  );
endinterface

// File: rtl/fifo_skew_reader_skew_lane.sv
// One row of the wavefront: decides whether this row reads at step t, registers its valid and
// zero-gates the FIFO's registered data.
module fifo_skew_reader_skew_lane
  import fifo_skew_reader_pkg::*;
#(
  parameter int unsigned ROW   = 0,
  parameter int unsigned LEN   = DefaultLen,
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned TW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TW-1:0]    t_i,
  input  logic             step_en_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             active_o,
  output logic             r_en_o,
  output logic             row_valid_o,
  output logic [WIDTH-1:0] row_data_o
);

  logic row_valid_q;

  // Row is inside its LEN-long window that starts ROW steps after row 0.
  always_comb begin
    int d;
    d        = int'(t_i) - int'(ROW);
    active_o = (d >= 0) && (d < int'(LEN));
  end

  assign r_en_o = step_en_i & active_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_valid_q <= 1'b0;
    end else begin
      row_valid_q <= r_en_o;
    end
  end

  assign row_valid_o = row_valid_q;
  assign row_data_o  = row_valid_q ? fifo_data_i : '0;

endmodule

// File: rtl/fifo_skew_reader.sv
// Drains ROWS FIFOs as a diagonally skewed wavefront of LEN elements per row; the whole front
// stalls in lockstep whenever any row that must read this step sees an empty FIFO.
module fifo_skew_reader
  import fifo_skew_reader_pkg::*;
#(
  parameter int unsigned ROWS  = DefaultRows,
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned LEN   = DefaultLen
) (
  input logic               clk,
  input logic               rst,
  fifo_skew_reader_if.slave bus
);

  localparam int unsigned   TW    = step_cnt_width(ROWS, LEN);
  localparam logic [TW-1:0] TLast = TW'(LEN + ROWS - 2);

  state_e                state_q;
  logic [TW-1:0]         t_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ROWS-1:0]       active;
  logic [ROWS-1:0]       r_en;
  logic [ROWS-1:0]       row_valid;
  logic [ROWS*WIDTH-1:0] row_data;
  logic                  advance;
  logic                  step_en;

  // Inactive rows are masked out so their empty flags cannot stall the front.
  assign advance = (state_q == StRun) & (&(~active | ~bus.fifo_empty));
  assign step_en = rst & advance;

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    fifo_skew_reader_skew_lane #(
      .ROW   (i),
      .LEN   (LEN),
      .WIDTH (WIDTH),
      .TW    (TW)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .t_i         (t_q),
      .step_en_i   (step_en),
      .fifo_data_i (bus.fifo_data[i*WIDTH +: WIDTH]),
      .active_o    (active[i]),
      .r_en_o      (r_en[i]),
      .row_valid_o (row_valid[i]),
      .row_data_o  (row_data[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StRun;
            t_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (advance) begin
            if (t_q == TLast) begin
              state_q <= StDrain;
              done_q  <= 1'b1;
            end else begin
              t_q <= t_q + TW'(1);
            end
          end
        end
        StDrain: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fifo_r_en = r_en;
  assign bus.row_valid = row_valid;
  assign bus.row_data  = row_data;

endmodule

// File: tb/tb_fifo_skew_reader.sv
// Bench for the skewed FIFO reader: table of directed scenarios plus random ones, each checked
// cycle by cycle against a step-level reference model; a ROWS=1, LEN=1 instance is checked by hand.
module tb_fifo_skew_reader;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN   = 4;
  localparam int          T     = LEN + ROWS - 1;
  localparam int          NC    = 48;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_skew_reader_if #(.ROWS(ROWS), .WIDTH(WIDTH)) bus ();
  fifo_skew_reader #(.ROWS(ROWS), .WIDTH(WIDTH), .LEN(LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  fifo_skew_reader_if #(.ROWS(1), .WIDTH(WIDTH)) bus1 ();
  fifo_skew_reader #(.ROWS(1), .WIDTH(WIDTH), .LEN(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int checks   = 0;
  int failures = 0;
  string cur;

  // FIFO models: row i holds elements {i, n} for n < wr_cnt[i]; data registered after r_en.
  int                 rd_ptr  [ROWS];
  int                 wr_cnt  [ROWS];
  logic [WIDTH-1:0]   fdata   [ROWS] = '{default: 8'hEE};
  logic               fifo_clear;
  logic [ROWS-1:0]    force_empty;
  logic [ROWS-1:0]    emp;
  logic [ROWS*WIDTH-1:0] fdat_flat;

  always @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (fifo_clear) begin
        rd_ptr[i] <= 0;
      end else if (bus.fifo_r_en[i]) begin
        fdata[i]  <= {4'(i), 4'(rd_ptr[i])};
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  always_comb begin
    emp       = '0;
    fdat_flat = '0;
    for (int i = 0; i < ROWS; i++) begin
      emp[i] = (rd_ptr[i] >= wr_cnt[i]) || force_empty[i];
      fdat_flat[i*WIDTH +: WIDTH] = fdata[i];
    end
  end

  assign bus.fifo_empty = emp;
  assign bus.fifo_data  = fdat_flat;

  logic [WIDTH-1:0] d1 = 8'h77;
  always @(posedge clk) if (bus1.fifo_r_en[0]) d1 <= 8'h5A;
  assign bus1.fifo_empty = 1'b0;
  assign bus1.fifo_data  = d1;

  // Per-cycle stimulus and expected trace.
  logic                  st_v [NC];
  logic [ROWS-1:0]       fe_v [NC];
  logic                  rl_v [NC];
  logic [ROWS-1:0]       e_ren  [NC];
  logic [ROWS-1:0]       e_val  [NC];
  logic [ROWS*WIDTH-1:0] e_dat  [NC];
  logic                  e_busy [NC];
  logic                  e_done [NC];

  typedef struct {
    string         name;
    logic [NC-1:0] starts;
    int            frow;
    int            ffrom;
    int            fto;
    int            rstc;
    int            done_a;
    int            done_b;
    bit            rnd;
  } scen_t;

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s cyc=%0d got=%0h want=%0h", cur, nm, k, act, exp);
    end
  endtask

  // Reference: one operation is the sequence of steps 0..T-1; a step issues reads for the rows
  // whose window covers it, or stalls if any of them is empty. Data comes from per-row pop counts.
  task automatic build_expected();
    int                    mode;
    int                    s;
    int                    pops [ROWS];
    bit                    stall;
    logic [ROWS-1:0]       act, ren, v_q, v_n;
    logic [ROWS*WIDTH-1:0] d_q, d_n;
    logic                  b_q, b_n, dn_q, dn_n;
    mode = 0; s = 0; v_q = '0; d_q = '0; b_q = 1'b0; dn_q = 1'b0;
    for (int i = 0; i < ROWS; i++) pops[i] = 0;
    for (int k = 0; k < NC; k++) begin
      e_val[k] = v_q; e_dat[k] = d_q; e_busy[k] = b_q; e_done[k] = dn_q;
      ren = '0; v_n = '0; d_n = '0; dn_n = 1'b0; b_n = b_q;
      if (rl_v[k]) begin
        mode = 0;
        b_n  = 1'b0;
      end else if (mode == 0) begin
        if (st_v[k]) begin
          mode = 1; s = 0; b_n = 1'b1;
        end
      end else if (mode == 1) begin
        act   = '0;
        stall = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
          if (s >= i && s <= i + int'(LEN) - 1) act[i] = 1'b1;
          if (act[i] && (fe_v[k][i] || pops[i] >= wr_cnt[i])) stall = 1'b1;
        end
        if (!stall) begin
          ren = act;
          for (int i = 0; i < ROWS; i++) begin
            if (act[i]) begin
              v_n[i] = 1'b1;
              d_n[i*WIDTH +: WIDTH] = {4'(i), 4'(pops[i])};
              pops[i]++;
            end
          end
          s++;
          if (s == T) begin
            mode = 2;
            dn_n = 1'b1;
          end
        end
      end else begin
        mode = 0;
        b_n  = 1'b0;
      end
      e_ren[k] = ren;
      v_q = v_n; d_q = d_n; b_q = b_n; dn_q = dn_n;
    end
  endtask

  task automatic run_scen(scen_t sc);
    int dones[$];
    int rc;
    cur = sc.name;
    rc  = sc.rnd ? (($urandom_range(0, 2) == 0) ? int'($urandom_range(3, NC - 5)) : -1) : sc.rstc;
    for (int i = 0; i < ROWS; i++) wr_cnt[i] = sc.rnd ? int'($urandom_range(6, 16)) : 16;
    for (int k = 0; k < NC; k++) begin
      st_v[k] = sc.rnd ? ($urandom_range(0, 4) == 0) : sc.starts[k];
      fe_v[k] = '0;
      for (int i = 0; i < ROWS; i++) begin
        if (sc.rnd) fe_v[k][i] = ($urandom_range(0, 3) == 0);
        else if (i == sc.frow && k >= sc.ffrom && k <= sc.fto) fe_v[k][i] = 1'b1;
      end
      rl_v[k] = (k == rc);
    end
    build_expected();
    rst = 1'b0; fifo_clear = 1'b1; bus.start = 1'b0; force_empty = '0;
    @(posedge clk);
    for (int k = 0; k < NC; k++) begin
      @(posedge clk);
      #1;
      rst = !rl_v[k]; fifo_clear = 1'b0; bus.start = st_v[k]; force_empty = fe_v[k];
      @(negedge clk);
      chk("r_en",      k, 64'(bus.fifo_r_en), 64'(e_ren[k]));
      chk("row_valid", k, 64'(bus.row_valid), 64'(e_val[k]));
      chk("row_data",  k, 64'(bus.row_data),  64'(e_dat[k]));
      chk("busy",      k, 64'(bus.busy),      64'(e_busy[k]));
      chk("done",      k, 64'(bus.done),      64'(e_done[k]));
      chk("read_empty", k, 64'(bus.fifo_r_en & bus.fifo_empty), 64'(0));
      if (bus.done === 1'b1) dones.push_back(k);
    end
    if (sc.done_a >= 0) chk("done_a", 0, 64'(dones.size() > 0 ? dones[0] : -1), 64'(sc.done_a));
    if (sc.done_b >= 0) chk("done_b", 0, 64'(dones.size() > 1 ? dones[1] : -1), 64'(sc.done_b));
  endtask

  scen_t tbl[$];

  initial begin
    fifo_clear  = 1'b1;
    force_empty = '0;
    bus.start   = 1'b0;
    bus1.start  = 1'b0;
    for (int i = 0; i < ROWS; i++) wr_cnt[i] = 16;

    tbl.push_back('{"no_stall",    48'h1,   -1, 0, 0, -1,  8, -1, 1'b0});
    tbl.push_back('{"row2_stall",  48'h1,    2, 4, 5, -1, 10, -1, 1'b0});
    tbl.push_back('{"row3_early",  48'h1,    3, 1, 3, -1,  8, -1, 1'b0});
    tbl.push_back('{"busy_starts", 48'h309, -1, 0, 0, -1,  8, 17, 1'b0});
    tbl.push_back('{"mid_reset",   48'h41,  -1, 0, 0,  4, 14, -1, 1'b0});
    for (int r = 0; r < 12; r++) tbl.push_back('{"random", 48'h0, -1, 0, 0, -1, -1, -1, 1'b1});

    foreach (tbl[n]) run_scen(tbl[n]);

    // ROWS=1, LEN=1: read at 1, valid+done at 2; flags packed {r_en, valid, busy, done}.
    begin
      logic [15:0] exp1;
      exp1 = 16'b0000_0111_1010_0000;
      cur  = "rows1_len1";
      rst  = 1'b0;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        rst = 1'b1; bus1.start = (k == 0);
        @(negedge clk);
        chk("flags1", k, 64'({bus1.fifo_r_en[0], bus1.row_valid[0], bus1.busy, bus1.done}),
            64'(exp1[k*4 +: 4]));
        chk("data1", k, 64'(bus1.row_data), 64'(k == 2 ? 8'h5A : 8'h00));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_skew_reader.md
# fifo_skew_reader

Read-side controller that drains ROWS parallel input FIFOs, one FIFO per systolic-array row, and emits one element per row per step with diagonal skew: row i starts i steps after row 0. It sits between the per-row synchronous FIFOs and the left edge of the systolic array. It turns a start pulse into a skewed, zero-padded wavefront of LEN elements per row. If any row that must read in the current step has an empty FIFO, the whole front stalls in lockstep.

## Interface
- ROWS, 4: number of FIFOs and array rows; must be ≥1.
- WIDTH, 8: element width in bits.
- LEN, 4: elements read from each FIFO per operation; must be ≥1.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  begin one operation; sampled only in IDLE.
- busy  out  1  high from the first RUN cycle through the done cycle, inclusive.
- done  out  1  one-cycle pulse coincident with the final row_valid.
- fifo_empty  in  ROWS  per-FIFO empty flag, combinational from the FIFO.
- fifo_r_en  out  ROWS  per-FIFO read enable.
- fifo_data  in  ROWS*WIDTH  per-FIFO registered read data; row i occupies bits [i*WIDTH +: WIDTH].
- row_data  out  ROWS*WIDTH  skewed data to the array; zero when the row's valid bit is low.
- row_valid  out  ROWS  per-row data-valid.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start.
  - RUN→DRAIN when the step counter advances past the last step, T−1, where T = LEN+ROWS−1.
  - DRAIN→IDLE unconditionally after one cycle.
- Step counter t: width clog2(LEN+ROWS). It clears to 0 on entering RUN and increments only on an advancing cycle.
- Row i is active at step t iff i ≤ t ≤ i+LEN−1.
- Step advances iff state is RUN and every active row has fifo_empty low. Empty flags of inactive rows are ignored.
- fifo_r_en[i] = RUN & advance & active(i,t). This is combinational, and forced to 0 while rst is low.
- On a stall cycle, no r_en is asserted on any row and t holds.
- row_valid[i] is a register loaded from fifo_r_en[i] each cycle.
- row_data[i] = row_valid[i] ? fifo_data[i] : 0. The FIFO presents data the cycle after r_en, so no extra data register is needed.
- done = DRAIN, or RUN on the cycle after the final read. Implement it as a register set when the final advance occurs.
- start is ignored outside IDLE, including on the done cycle.
- Reset values: state IDLE, t=0, busy 0, done 0, row_valid 0, row_data 0, fifo_r_en 0.

## Timing
- start sampled high at cycle c gives RUN at c+1. With no stalls:
  - step s issues reads at c+1+s;
  - row i reads during cycles c+1+i .. c+i+LEN;
  - row_valid[i] is high during cycles c+2+i .. c+1+i+LEN.
- Final read at c+T; final row_valid, done, and last busy cycle at c+T+1; IDLE at c+T+2. The earliest next start is accepted at c+T+2.
- Each stall cycle delays all subsequent events by exactly one cycle. No partial-row advance is permitted.
- Reset mid-operation: r_en drops in the same cycle rst is low. The next cycle shows all outputs at reset values. No FIFO read is issued until the next start.
- Never read a FIFO whose empty flag is high in that cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DRAIN);
  - a function for step-counter width;
  - default ROWS, WIDTH, LEN constants used by the array top.
- Sub-module skew_lane: one per row. It computes active(i,t), holds the row_valid flop, and applies zero-gating to row_data. The top holds the FSM, the step counter, and the AND-reduction of the active rows' non-empty flags.

## Test plan
Default parameters (ROWS=4, WIDTH=8, LEN=4). FIFO row i is preloaded with 0x(i)0..0x(i)3, start at cycle 0, unless stated.
- No stalls:
  - row_valid[0] is high during cycles 2–5 with data 00,01,02,03;
  - row_valid[3] is high during cycles 5–8 with data 30..33;
  - row_data is 0 elsewhere;
  - done at cycle 8 only; busy during cycles 1–8.
- Row 2 empty for cycles 4–5 (its first active step is 2): fifo_r_en = 0 on all rows in cycles 4–5, and done moves to cycle 10. Per-row data order is unchanged.
- Row 3 empty during cycles 1–3, before its active window: no stall, and timing is identical to the first scenario.
- start pulsed at cycles 3 and 8 while busy: ignored. A start at cycle 9 is accepted and row_valid[0] rises at cycle 11.
- rst low at cycle 4:
  - fifo_r_en = 0 at cycle 4;
  - at cycle 5, row_valid = 0, busy = 0, and no done pulse;
  - a fresh start then behaves as in the first scenario.
- With ROWS=1, LEN=1 and start at cycle 0: one read at cycle 1, row_valid and done at cycle 2.
